// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: drives the shared weight/input BRAM address, multiplies the
// negedge-registered read data pairwise and accumulates N signed Q8.8 products.
// Emits one saturated Q8.8 result with a single-cycle DONE per accepted START.
module neuron_mac_seq #(
   parameter int unsigned N_WEIGHTS = 28,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned FRAC      = 8,
   parameter int unsigned ACC_W     = 40
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   output logic [ADDR_W-1:0] W_ADDR,
   output logic              W_EN,
   output logic              W_WE,
   input  logic [DATA_W-1:0] W_DO,
   input  logic [DATA_W-1:0] X_DO,
   output logic [DATA_W-1:0] Y,
   output logic              DONE,
   output logic              BUSY
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WEIGHTS - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      $signed({{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}});
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      $signed({{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}});

   typedef enum logic [1:0] {StIdle, StFetch, StDrain, StOut} state_t;

   state_t                    state_q, state_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic                      en_q, en_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic [DATA_W-1:0]         y_q, y_d;
   logic signed [PROD_W-1:0]  prod_q, prod_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;

   logic signed [PROD_W-1:0]  w_ext, x_ext;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   shifted;

   // Read port is never written from this block.
   assign W_WE   = 1'b0;
   assign W_ADDR = addr_q;
   assign W_EN   = en_q;
   assign BUSY   = busy_q;
   assign DONE   = done_q;
   assign Y      = y_q;

   // Operand extension, product sign extension and output scaling.
   always_comb begin
      w_ext    = $signed({{DATA_W{W_DO[DATA_W-1]}}, W_DO});
      x_ext    = $signed({{DATA_W{X_DO[DATA_W-1]}}, X_DO});
      prod_ext = $signed({{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q});
      // Arithmetic shift floors toward -inf; no rounding.
      shifted  = acc_q >>> FRAC;
   end

   // Next-state and datapath update for the sequencer.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      en_d    = en_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      y_d     = y_q;
      prod_d  = prod_q;
      acc_d   = acc_q;
      unique case (state_q)
         StIdle: begin
            if (START) begin
               state_d = StFetch;
               addr_d  = '0;
               en_d    = 1'b1;
               busy_d  = 1'b1;
               acc_d   = '0;
               // Clearing P makes the first FETCH accumulate zero.
               prod_d  = '0;
            end
         end
         StFetch: begin
            prod_d = w_ext * x_ext;
            acc_d  = acc_q + prod_ext;
            if (addr_q == LAST_ADDR) begin
               en_d    = 1'b0;
               state_d = StDrain;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         StDrain: begin
            acc_d   = acc_q + prod_ext;
            state_d = StOut;
         end
         StOut: begin
            if (shifted > SAT_MAX) begin
               y_d = {1'b0, {(DATA_W - 1){1'b1}}};
            end else if (shifted < SAT_MIN) begin
               y_d = {1'b1, {(DATA_W - 1){1'b0}}};
            end else begin
               y_d = shifted[DATA_W-1:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         addr_q  <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         y_q     <= '0;
         prod_q  <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         y_q     <= y_d;
         prod_q  <= prod_d;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench for neuron_mac_seq: the stimulus pushes the expected result
// and DONE edge for each accepted START; a monitor pops and compares on DONE.
module tb_neuron_mac_seq;

   localparam int N = 28;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic [4:0]  W_ADDR;
   logic        W_EN, W_WE;
   logic [15:0] W_DO = '0;
   logic [15:0] X_DO = '0;
   logic [15:0] Y;
   logic        DONE, BUSY;

   logic [15:0] w_mem [N];
   logic [15:0] x_mem [N];

   typedef struct {
      logic [15:0] y;
      int          edge_no;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   neuron_mac_seq dut (
      .CLK    (CLK),
      .RST    (RST),
      .START  (START),
      .W_ADDR (W_ADDR),
      .W_EN   (W_EN),
      .W_WE   (W_WE),
      .W_DO   (W_DO),
      .X_DO   (X_DO),
      .Y      (Y),
      .DONE   (DONE),
      .BUSY   (BUSY)
   );

   always #5 CLK = ~CLK;

   // Rising-edge counter: edge numbers used by the scoreboard.
   always @(posedge CLK) cyc <= cyc + 1;

   // BRAM pair model: registered read on the falling edge when enabled.
   always @(negedge CLK) begin
      if (W_EN && W_ADDR < 5'(N)) begin
         W_DO <= w_mem[W_ADDR];
         X_DO <= x_mem[W_ADDR];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: exact dot product, floor-scaled by 2^8, clipped to 16 bits.
   function automatic logic [15:0] model_y();
      longint s = 0;
      for (int i = 0; i < N; i++)
         s += longint'($signed(w_mem[i])) * longint'($signed(x_mem[i]));
      s = s >>> 8;
      if (s > 32767) return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return s[15:0];
   endfunction

   // Monitor: compare every DONE against the head of the scoreboard.
   always @(posedge CLK) begin
      #1;
      check("w_we_zero", W_WE, 0);
      check("w_addr_range", W_ADDR <= 5'(N - 1), 1);
      if (DONE) begin
         if (sb.size() == 0) begin
            check("unexpected_done", DONE, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("y_value", Y, e.y);
            check("done_edge", cyc, e.edge_no);
            check("busy_low_at_done", BUSY, 0);
         end
      end
   end

   task automatic fill(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] x);
      for (int i = 0; i < N; i++) begin
         w_mem[i] = (i % 2 == 0) ? w0 : w1;
         x_mem[i] = x;
      end
   endtask

   // Pulse START for edge 0; returns #1 after edge 0.
   task automatic start_pulse();
      exp_t e;
      @(negedge CLK);
      START = 1'b1;
      e.y = model_y();
      e.edge_no = cyc + 1 + N + 2;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      START = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(posedge CLK);
         #2;
         t++;
      end
      if (sb.size() != 0) begin
         check("done_timeout", 0, 1);
         sb.delete();
      end
      repeat (2) @(posedge CLK);
   endtask

   task automatic run_simple(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] x);
      fill(w0, w1, x);
      start_pulse();
      wait_done();
   endtask

   initial begin
      fill(16'h0000, 16'h0000, 16'h0000);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      check("rst_w_addr", W_ADDR, 0);
      check("rst_w_en", W_EN, 0);
      check("rst_y", Y, 0);
      check("rst_done", DONE, 0);
      check("rst_busy", BUSY, 0);

      // Unit vector with address sequencing.
      fill(16'h0100, 16'h0100, 16'h0100);
      start_pulse();
      for (int k = 0; k < N; k++) begin
         check("addr_seq", W_ADDR, k);
         check("en_in_fetch", W_EN, 1);
         @(posedge CLK);
         #1;
      end
      wait_done();
      check("unit_y_held", Y, 16'h1C00);

      // Cancelling pattern and BUSY width.
      begin
         int busy_cnt = 0;
         fill(16'h0100, 16'hFF00, 16'h0200);
         start_pulse();
         for (int k = 0; k < 40; k++) begin
            if (BUSY) busy_cnt++;
            @(posedge CLK);
            #1;
         end
         check("busy_cycles", busy_cnt, 30);
         wait_done();
      end

      run_simple(16'h7FFF, 16'h7FFF, 16'h7FFF);
      run_simple(16'h8000, 16'h8000, 16'h0100);
      run_simple(16'h0001, 16'h0001, 16'h0001);
      run_simple(16'hFFFF, 16'hFFFF, 16'h0001);

      // Reset mid-run at edge 10, after a run that left Y nonzero.
      run_simple(16'h0100, 16'h0100, 16'h0100);
      start_pulse();
      repeat (9) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      sb.delete();
      @(posedge CLK);
      #1;
      check("midrst_w_en", W_EN, 0);
      check("midrst_busy", BUSY, 0);
      check("midrst_y", Y, 0);
      check("midrst_done", DONE, 0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (40) @(posedge CLK);
      run_simple(16'h0100, 16'h0100, 16'h0100);

      // START held for 40 cycles: second run accepted at edge 31.
      begin
         exp_t e;
         fill(16'h0180, 16'hFE40, 16'h0033);
         @(negedge CLK);
         START = 1'b1;
         e.y = model_y();
         e.edge_no = cyc + 1 + N + 2;
         sb.push_back(e);
         e.edge_no = cyc + 1 + 31 + N + 2;
         sb.push_back(e);
         repeat (40) @(negedge CLK);
         START = 1'b0;
         wait_done();
      end

      // Random data with START noise while busy.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++) begin
            if (r % 2 == 0) begin
               w_mem[i] = 16'($urandom);
               x_mem[i] = 16'($urandom);
            end else begin
               w_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
               x_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
            end
         end
         start_pulse();
         for (int k = 1; k < 30; k++) begin
            @(negedge CLK);
            START = 1'($urandom);
         end
         @(negedge CLK);
         START = 1'b0;
         wait_done();
      end

      repeat (5) @(posedge CLK);
      check("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Sequencer and multiply-accumulate stage that sits directly downstream of one neuron's weight BRAM and its matching input-vector BRAM. It drives the shared read address, consumes the negedge-registered read data from both memories, and accumulates the N signed Q8.8 products. It then emits one saturated Q8.8 pre-activation value per START, with a one-cycle DONE pulse, to the activation stage.

## Interface
- N_WEIGHTS, 28: number of weight/input pairs per neuron (memory depth).
- ADDR_W, 5: address width; must satisfy 2^ADDR_W >= N_WEIGHTS.
- DATA_W, 16: weight, input and result width, signed two's complement.
- FRAC, 8: fractional bits of weight, input and result (Q8.8).
- ACC_W, 40: accumulator width; must be >= 2*DATA_W + ceil(log2(N_WEIGHTS)).

- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begin one dot product; sampled only in IDLE.
- W_ADDR  out  ADDR_W  shared read address to the weight and input BRAMs.
- W_EN  out  1  BRAM enable; high only while addresses are being issued.
- W_WE  out  1  BRAM write enable; constant 0.
- W_DO  in  DATA_W  weight read data, updated by the BRAM on the falling edge.
- X_DO  in  DATA_W  input read data, same timing as W_DO.
- Y  out  DATA_W  saturated Q8.8 dot product; held until the next DONE.
- DONE  out  1  one-cycle pulse; Y is valid in the same cycle.
- BUSY  out  1  high from the cycle after START is accepted until DONE.

## Operation
- All outputs are registered. Reset values: W_ADDR=0, W_EN=0, W_WE=0, Y=0, DONE=0, BUSY=0, accumulator=0, product register=0, state=IDLE.
- States:
  - IDLE: wait for START. On START, clear the accumulator, set W_ADDR=0, set W_EN=1 and BUSY=1, and go to FETCH.
  - FETCH: register the product P <= W_DO * X_DO, a full 2*DATA_W signed result in Q16.16. Accumulate the previous P. Increment W_ADDR. After address N_WEIGHTS-1 has been issued, drop W_EN and go to DRAIN.
  - DRAIN: register the final product, then add it to the accumulator. Go to OUT.
  - OUT: Y <= sat(ACC >>> FRAC). DONE=1 for this cycle only. BUSY=0. Return to IDLE.
- Arithmetic:
  - Products are sign-extended to ACC_W before accumulation.
  - The accumulator wraps at ACC_W bits; the width rule above guarantees no overflow occurs.
  - The shift is arithmetic and truncates toward -inf; no rounding.
  - Saturation: results > 32767 become 0x7FFF, results < -32768 become 0x8000.
- START while BUSY is ignored and does not restart, queue, or alter the run.
- W_ADDR never exceeds N_WEIGHTS-1 and holds its last value in IDLE. W_EN is low outside FETCH.
- The block does not mask the BRAM contents on W_EN; data sampled outside FETCH is never accumulated.

## Timing
- Edge 0 is the rising edge that samples START in IDLE.
- Address k (0..N-1) is presented after edge k. The BRAM drives data on the following falling edge, and the block samples it at edge k+1.
- Product k is registered at edge k+1. It is accumulated at edge k+2.
- The last accumulation happens at edge N+1. Y and DONE are registered at edge N+2, which is edge 30 for N=28.
- The earliest next START is sampled at edge N+3. Throughput is one dot product per N+3 cycles.
- RST mid-run takes effect at the next edge and returns all outputs to their reset values. No DONE is produced for the aborted run, and Y is cleared to 0.
- RST and START high together: RST wins and START is ignored.

## Test plan
- Unit vector: all W=0x0100, all X=0x0100, START at edge 0. Require W_ADDR to sequence 0..27 on consecutive cycles, W_WE=0 throughout, and DONE at edge 30 with Y=0x1C00 (28.0).
- Cancelling: W alternates 0x0100/0xFF00, X=0x0200. Require Y=0x0000 and BUSY high for exactly 30 cycles.
- Saturation: all W=0x7FFF, X=0x7FFF requires Y=0x7FFF. All W=0x8000, X=0x0100 requires Y=0x8000 (-3584 clipped).
- Truncation: all W=0x0001, X=0x0001 requires Y=0x0000. All W=0xFFFF, X=0x0001 requires Y=0xFFFF (floor of -28/256).
- Reset mid-run: assert RST for one cycle at edge 10. Require W_EN=0, BUSY=0, Y=0 and no DONE. A fresh START then gives the correct unit-vector result 0x1C00.
- START held high for 40 cycles: require exactly one DONE by edge 30 and a second run starting at edge 31. Assert no DONE in the cycle directly after the first DONE.
